// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for one block: owns the PC, applies the
// scheduler's branch decision on each advance and reads program memory over valid/ready.
module pc_fetch_unit #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             fetch_req,
  input  logic                             pc_advance,
  input  logic                             load_pc,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  input  logic                             halt,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_done,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
  output logic                             busy,
  output logic [1:0]                       dbg_state
);

  // Memory handshake: a transfer happens on a clock edge where mem_read_valid
  // and mem_read_ready are both 1. Once valid is raised, valid and address stay
  // stable until that transfer; valid never drops without a transfer (except reset).

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    REQ     = 2'd2,
    FETCHED = 2'd3
  } state_t;

  state_t                             state, state_n;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   pc_n, addr_n;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_n;
  logic                               valid_n, done_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      pc               <= '0;
      instruction      <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      fetch_done       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      instruction      <= instr_n;
      mem_read_valid   <= valid_n;
      mem_read_address <= addr_n;
      fetch_done       <= done_n;
      busy             <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instruction;
    valid_n = mem_read_valid;
    addr_n  = mem_read_address;
    done_n  = fetch_done;
    unique case (state)
      IDLE: begin
        if (start) begin
          pc_n    = '0;
          state_n = READY;
        end
      end
      READY: begin
        if (halt) begin
          state_n = IDLE;
        end else if (fetch_req) begin
          valid_n = 1'b1;
          addr_n  = pc;
          state_n = REQ;
        end
      end
      REQ: begin
        // halt/start/pc_advance are deliberately ignored: a request is never abandoned
        if (mem_read_valid && mem_read_ready) begin
          instr_n = mem_read_data;
          valid_n = 1'b0;
          done_n  = 1'b1;
          state_n = FETCHED;
        end
      end
      FETCHED: begin
        if (halt) begin
          done_n  = 1'b0;
          state_n = IDLE;
        end else if (pc_advance) begin
          pc_n    = load_pc ? next_pc : pc + PROGRAM_MEM_ADDR_BITS'(1);
          done_n  = 1'b0;
          state_n = READY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: drivers push expected captures into a queue,
// a negedge monitor pops and compares whenever a memory transfer completes.
module tb_pc_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, fetch_req, pc_advance, load_pc, halt;
  logic [AW-1:0] next_pc;
  logic          mem_read_valid, mem_read_ready;
  logic [AW-1:0] mem_read_address, pc;
  logic [DW-1:0] mem_read_data, instruction;
  logic          fetch_done, busy;
  logic [1:0]    dbg_state;

  pc_fetch_unit #(.PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .fetch_req(fetch_req),
    .pc_advance(pc_advance), .load_pc(load_pc), .next_pc(next_pc), .halt(halt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .instruction(instruction), .fetch_done(fetch_done), .pc(pc), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // {address, instruction} of every transfer the drivers make
  logic [AW+DW-1:0] exp_q[$];

  // reference model: the PC the kernel should be at
  int model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  logic          hs_pend = 1'b0;
  logic [AW-1:0] hs_addr;
  logic [AW+DW-1:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      hs_pend = 1'b0;
    end else begin
      if (hs_pend) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_capture", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cap_addr", 32'(hs_addr), 32'(e[AW+DW-1:DW]));
          chk("cap_instr", 32'(instruction), 32'(e[DW-1:0]));
          chk("cap_done", 32'(fetch_done), 32'd1);
        end
      end
      hs_pend = mem_read_valid && mem_read_ready;
      hs_addr = mem_read_address;
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start = 0; fetch_req = 0; pc_advance = 0; load_pc = 0; halt = 0;
    next_pc = '0; mem_read_ready = 0; mem_read_data = '0;
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
    model_pc = 0;
    chk("start_pc", 32'(pc), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_fetch(input logic [DW-1:0] d, input int waits, input bit hold_req,
                          input bit noise_in_req);
    fetch_req = 1; step();
    if (!hold_req) fetch_req = 0;
    chk("req_valid", 32'(mem_read_valid), 32'd1);
    chk("req_addr", 32'(mem_read_address), 32'(model_pc));
    for (int i = 0; i < waits; i++) begin
      mem_read_data = DW'($urandom);
      if (noise_in_req) begin halt = 1; start = 1; pc_advance = 1; end
      step();
      halt = 0; start = 0; pc_advance = 0;
      chk("wait_valid", 32'(mem_read_valid), 32'd1);
      chk("wait_addr", 32'(mem_read_address), 32'(model_pc));
      chk("wait_no_done", 32'(fetch_done), 32'd0);
    end
    if (noise_in_req) chk("req_ignores_halt_state", 32'(dbg_state), 32'd2);
    mem_read_ready = 1; mem_read_data = d;
    exp_q.push_back({AW'(model_pc), d});
    step();
    mem_read_ready = 0; mem_read_data = DW'($urandom);
    chk("done_latency", 32'(fetch_done), 32'd1);
    chk("valid_dropped", 32'(mem_read_valid), 32'd0);
    if (hold_req) begin
      step();
      chk("held_req_no_refetch", 32'(mem_read_valid), 32'd0);
      chk("held_instr", 32'(instruction), 32'(d));
    end
    fetch_req = 0;
  endtask

  task automatic do_advance(input bit ld, input logic [AW-1:0] npc);
    pc_advance = 1; load_pc = ld; next_pc = npc; step();
    pc_advance = 0; load_pc = $urandom_range(0, 1); next_pc = AW'($urandom);
    model_pc = ld ? int'(npc) : (model_pc + 1) % (1 << AW);
    chk("adv_pc", 32'(pc), 32'(model_pc));
    chk("adv_done_clr", 32'(fetch_done), 32'd0);
    chk("adv_busy", 32'(busy), 32'd1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    idle_inputs();
    model_pc = 0;
    reset = 0;
    #2;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // inputs other than start are ignored in IDLE
    fetch_req = 1; pc_advance = 1; step(); idle_inputs();
    chk("idle_ignores_req", 32'(mem_read_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 1: zero-wait fetch at PC 0
    do_start();
    do_fetch(16'h1234, 0, 0, 0);
    chk("t1_instr", 32'(instruction), 32'h1234);
    // 2: ready held off five cycles
    do_advance(0, 8'h00);
    do_fetch(16'hBEEF, 5, 0, 0);
    // 3: branch vs sequential from 0x10
    do_advance(1, 8'h10);
    do_fetch(16'h0A0A, 1, 0, 0);
    do_advance(1, 8'h05);
    chk("t3_branch", 32'(pc), 32'h05);
    do_fetch(16'h0B0B, 0, 0, 0);
    do_advance(1, 8'h10);
    do_fetch(16'h0C0C, 0, 1, 0);
    do_advance(0, 8'h77);
    chk("t3_seq", 32'(pc), 32'h11);
    // 4: wrap
    do_fetch(16'h0D0D, 0, 0, 0);
    do_advance(1, 8'hFF);
    do_fetch(16'h0E0E, 2, 0, 0);
    do_advance(0, 8'h33);
    chk("t4_wrap", 32'(pc), 32'h00);
    // 5: halt ignored in REQ, halt beats pc_advance in FETCHED
    do_fetch(16'h5A5A, 2, 0, 1);
    halt = 1; pc_advance = 1; load_pc = 1; next_pc = 8'h99; step(); idle_inputs();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_pc_kept", 32'(pc), 32'(model_pc));
    chk("t5_done_clr", 32'(fetch_done), 32'd0);
    chk("t5_state", 32'(dbg_state), 32'd0);
    // halt beats fetch_req in READY
    do_start();
    halt = 1; fetch_req = 1; step(); idle_inputs();
    chk("ready_halt_wins", 32'(busy), 32'd0);
    chk("ready_halt_no_req", 32'(mem_read_valid), 32'd0);

    // randomized kernel runs
    do_start();
    for (int k = 0; k < 40; k++) begin
      do_fetch(DW'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) == 0) begin
        halt = 1; step(); idle_inputs();
        chk("rnd_halt_busy", 32'(busy), 32'd0);
        do_start();
      end else begin
        do_advance(1'($urandom_range(0, 1)), AW'($urandom));
      end
    end

    // 6: async reset in the middle of a request
    fetch_req = 1; step(); fetch_req = 0;
    chk("t6_valid_before", 32'(mem_read_valid), 32'd1);
    #2 reset = 0;
    #1;
    chk("t6_valid", 32'(mem_read_valid), 32'd0);
    chk("t6_addr", 32'(mem_read_address), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_instr", 32'(instruction), 32'd0);
    chk("t6_done", 32'(fetch_done), 32'd0);
    @(posedge clk); #1 reset = 1;
    do_start();
    do_fetch(16'hCAFE, 1, 0, 0);

    step(); step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
